free_list: RTL and testbench
============================

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter NUM_LRS, default 10, the number of logical registers mapped by the RAT.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, the physical tag width; NUM_PRS = 2**ADDR_WIDTH.
REQ-003 SHALL have port clk, input, 1, clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port alloc_req, input, 1, rename stage consumes alloc_tag this cycle.
REQ-006 SHALL have port alloc_tag, output, ADDR_WIDTH, next free physical tag at the speculative head.
REQ-007 SHALL have port alloc_valid, output, 1, alloc_tag is meaningful (speculative count > 0).
REQ-008 SHALL have port release_valid, input, 1, retire returns release_tag to the list.
REQ-009 SHALL have port release_tag, input, ADDR_WIDTH, tag being freed (previous mapping of a retired LR).
REQ-010 SHALL have port commit_valid, input, 1, the oldest speculative allocation is now architectural.
REQ-011 SHALL have port flush, input, 1, mispredict; discard all uncommitted allocations.
REQ-012 SHALL have port free_count, output, ADDR_WIDTH+1, speculative free entries.
REQ-013 SHALL have port err, output, 2, sticky flags: [0] release overflow, [1] commit underflow.

Function
REQ-014 SHALL hold tags in a NUM_PRS-entry ring with wrap-bit pointers: tail, spec_head, commit_head (ADDR_WIDTH+1 bits each).
REQ-015 SHALL drive alloc_tag = ring[spec_head] and free_count = tail - spec_head combinationally; alloc_valid = (free_count != 0).
REQ-016 SHALL advance spec_head by 1 when alloc_req && alloc_valid && !flush; alloc_req with alloc_valid low is ignored.
REQ-017 SHALL, on release_valid, write release_tag at tail and advance tail by 1, when (tail - commit_head) < NUM_PRS - NUM_LRS; otherwise drop it and set err[0].
REQ-018 SHALL advance commit_head by 1 on commit_valid when commit_head != spec_head; otherwise ignore it and set err[1].
REQ-019 SHALL, on flush, set spec_head <= commit_head next cycle; a same-cycle alloc is ignored, while a same-cycle release and commit are still applied (commit updates commit_head first, and spec_head takes the updated value).
REQ-020 SHALL not bypass a same-cycle release to alloc: empty plus release gives alloc_valid high only on the following cycle.
REQ-021 SHALL, for simultaneous alloc and release, leave free_count unchanged.
REQ-022 SHALL make all pointer arithmetic wrap modulo 2*NUM_PRS, with no saturation.

Reset
REQ-023 SHALL, on rst, load ring[k] = NUM_LRS + k for k = 0 .. NUM_PRS-NUM_LRS-1, consistent with RAT reset mapping LR i -> tag i.
REQ-024 SHALL, on rst, clear spec_head and commit_head to 0, set tail = NUM_PRS - NUM_LRS and clear err; outputs are then alloc_tag = NUM_LRS, alloc_valid = 1, free_count = NUM_PRS - NUM_LRS.
REQ-025 SHALL give rst priority over all inputs, including mid-flush and mid-allocation.

Configuration
REQ-026 SHALL, with OOO_FREE_LIST_ERR_EN defined, implement the err flags and their checks; the overflow drop in REQ-017 applies in both builds.
REQ-027 SHALL, without OOO_FREE_LIST_ERR_EN, tie err to 2'b00 and remove the sticky registers.

Structure
REQ-028 SHALL take NUM_LRS, ADDR_WIDTH, NUM_PRS and the tag typedef (ADDR_WIDTH bits) from shared package ooo_pkg, shared with rat.
REQ-029 SHALL place the ring storage in sub-module free_list_ram (1 write, 1 async read port); pointer logic stays in free_list.

Verification
REQ-030 SHALL cover reset: after rst, alloc_tag=10, free_count=22, alloc_valid=1, err=0.
REQ-031 SHALL cover drain: 22 consecutive allocs -> tags 10..31 in order, free_count=0, alloc_valid=0; 23rd alloc_req leaves state unchanged.
REQ-032 SHALL cover flush: 5 allocs, 2 commits, flush -> free_count=20, alloc_tag=12.
REQ-033 SHALL cover release/alloc: empty list plus release tag 3 -> alloc_valid=0 that cycle, 1 next cycle with alloc_tag=3; simultaneous alloc and release at count 5 -> count stays 5.
REQ-034 SHALL cover errors: release at reset state (full) -> tag dropped, err[0]=1; commit with nothing speculative -> err[1]=1; both remain set until rst.
REQ-035 SHALL cover a same-cycle flush, commit and release after 3 allocs -> commit_head=1, spec_head=1, tail advanced by 1, free_count=22.

Source files
------------

// File: rtl/ooo_pkg.sv
// Shared out-of-order core package: register-file sizing and the physical
// tag type, used by both the RAT and the free list.
package ooo_pkg;

  localparam int NUM_LRS    = 10;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_PRS    = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] tag_t;

  // Reset content of free-list slot k: the RAT owns tags 0..NUM_LRS-1 at
  // reset, so the free list starts with every remaining tag in order.
  function automatic int init_tag(input int k, input int num_lrs);
    return num_lrs + k;
  endfunction

endpackage

// File: rtl/free_list_ram.sv
// Ring storage for the free list: one synchronous write port, one
// asynchronous read port. Reset preloads the tags not owned by the RAT.
module free_list_ram
  import ooo_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter int INIT_BASE = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [ADDR_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [ADDR_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [ADDR_W-1:0] mem_q [DEPTH];

  // Preload slots 0..DEPTH-INIT_BASE-1 on reset, otherwise take the write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (k < DEPTH - INIT_BASE) mem_q[k] <= ADDR_W'(init_tag(k, INIT_BASE));
        else                       mem_q[k] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/free_list.sv
// Physical-register free list for the rename stage. Three wrap-bit pointers
// walk a ring: [commit_head, spec_head) holds speculatively allocated tags,
// [spec_head, tail) holds tags free for allocation. A flush rewinds
// spec_head to commit_head, returning every uncommitted tag to the pool.
// Build option: define OOO_FREE_LIST_ERR_EN for sticky err flags
// (err[0] release overflow, err[1] commit underflow); otherwise err reads 0.
module free_list #(
  parameter int NUM_LRS    = ooo_pkg::NUM_LRS,
  parameter int ADDR_WIDTH = ooo_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_req,
  output logic [ADDR_WIDTH-1:0] alloc_tag,
  output logic                  alloc_valid,
  input  logic                  release_valid,
  input  logic [ADDR_WIDTH-1:0] release_tag,
  input  logic                  commit_valid,
  input  logic                  flush,
  output logic [ADDR_WIDTH:0]   free_count,
  output logic [1:0]            err
);

  localparam int PW      = ADDR_WIDTH + 1;
  localparam int NUM_PRS = 2 ** ADDR_WIDTH;
  localparam logic [PW-1:0] CAP = PW'(NUM_PRS - NUM_LRS);

  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] spec_head_q, spec_head_d;
  logic [PW-1:0] commit_head_q, commit_head_d;
  logic [PW-1:0] occupancy;
  logic          do_alloc, do_release, do_commit;

  assign free_count  = tail_q - spec_head_q;
  assign alloc_valid = (free_count != '0);

  // Accept each request, then step the pointers; commit lands first so the
  // release capacity check and the flush rewind both see the new commit_head.
  always_comb begin
    do_alloc      = alloc_req && alloc_valid && !flush;
    do_commit     = commit_valid && (commit_head_q != spec_head_q);
    commit_head_d = commit_head_q + {{ADDR_WIDTH{1'b0}}, do_commit};
    occupancy     = tail_q - commit_head_d;
    do_release    = release_valid && (occupancy < CAP);
    tail_d        = tail_q + {{ADDR_WIDTH{1'b0}}, do_release};
    if (flush) spec_head_d = commit_head_d;
    else       spec_head_d = spec_head_q + {{ADDR_WIDTH{1'b0}}, do_alloc};
  end

  // Pointer registers; reset hands out tags NUM_LRS.. first.
  always_ff @(posedge clk) begin
    if (rst) begin
      tail_q        <= CAP;
      spec_head_q   <= '0;
      commit_head_q <= '0;
    end else begin
      tail_q        <= tail_d;
      spec_head_q   <= spec_head_d;
      commit_head_q <= commit_head_d;
    end
  end

  free_list_ram #(
    .ADDR_W    (ADDR_WIDTH),
    .INIT_BASE (NUM_LRS)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (do_release),
    .waddr_i (tail_q[ADDR_WIDTH-1:0]),
    .wdata_i (release_tag),
    .raddr_i (spec_head_q[ADDR_WIDTH-1:0]),
    .rdata_o (alloc_tag)
  );

`ifdef OOO_FREE_LIST_ERR_EN
  logic [1:0] err_q, err_d;

  // Sticky error flags: rejected release, commit with nothing speculative.
  always_comb begin
    err_d = err_q | {commit_valid && !do_commit, release_valid && !do_release};
  end

  // Error register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 2'b00;
`endif

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: a queue-based reference model of the free
// pool predicts the outputs after each clock, a monitor compares on negedge.
module tb_free_list;
  import ooo_pkg::*;

  localparam int AW  = 5;
  localparam int CAP = 22;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_req;
  logic [AW-1:0] alloc_tag;
  logic          alloc_valid;
  logic          release_valid;
  logic [AW-1:0] release_tag;
  logic          commit_valid;
  logic          flush;
  logic [AW:0]   free_count;
  logic [1:0]    err;

  free_list #(.NUM_LRS(10), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_req     (alloc_req),
    .alloc_tag     (alloc_tag),
    .alloc_valid   (alloc_valid),
    .release_valid (release_valid),
    .release_tag   (release_tag),
    .commit_valid  (commit_valid),
    .flush         (flush),
    .free_count    (free_count),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         av;
    tag_t       tag;
    int         fc;
    logic [1:0] e;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: free tags in hand-out order, speculative tags in age order.
  tag_t       freeq[$];
  tag_t       specq[$];
  logic [1:0] err_m;

  function automatic void model_reset();
    freeq.delete();
    specq.delete();
    for (int k = 0; k < CAP; k++) freeq.push_back(tag_t'(10 + k));
    err_m = 2'b00;
  endfunction

  function automatic void model_step(input bit r, input bit a, input bit rv,
                                     input tag_t rt, input bit c, input bit f);
    bit cm, av;
    if (r) begin
      model_reset();
      return;
    end
    cm = c && (specq.size() != 0);
    av = (freeq.size() != 0);
    if (cm) void'(specq.pop_front());
`ifdef OOO_FREE_LIST_ERR_EN
    if (c && !cm) err_m[1] = 1'b1;
`endif
    if (a && av && !f) specq.push_back(freeq.pop_front());
    if (rv) begin
      if (specq.size() + freeq.size() < CAP) freeq.push_back(rt);
`ifdef OOO_FREE_LIST_ERR_EN
      else err_m[0] = 1'b1;
`endif
    end
    if (f) begin
      freeq = {specq, freeq};
      specq.delete();
    end
  endfunction

  task automatic cycle(input bit r, input bit a, input bit rv, input tag_t rt,
                       input bit c, input bit f);
    exp_t e;
    rst = r; alloc_req = a; release_valid = rv; release_tag = rt;
    commit_valid = c; flush = f;
    @(posedge clk);
    model_step(r, a, rv, rt, c, f);
    e.av  = (freeq.size() != 0);
    e.tag = e.av ? freeq[0] : '0;
    e.fc  = freeq.size();
    e.e   = err_m;
    sb.push_back(e);
    #1;
  endtask

  // Monitor: compare every predicted post-edge state away from the edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (alloc_valid !== e.av) begin
        errors++;
        $display("FAIL alloc_valid: got %0b expected %0b at %0t", alloc_valid, e.av, $time);
      end
      checks++;
      if (free_count !== (AW+1)'(e.fc)) begin
        errors++;
        $display("FAIL free_count: got %0d expected %0d at %0t", free_count, e.fc, $time);
      end
      checks++;
      if (err !== e.e) begin
        errors++;
        $display("FAIL err: got %b expected %b at %0t", err, e.e, $time);
      end
      if (e.av) begin
        checks++;
        if (alloc_tag !== e.tag) begin
          errors++;
          $display("FAIL alloc_tag: got %0d expected %0d at %0t", alloc_tag, e.tag, $time);
        end
      end
    end
  end

  initial begin
    model_reset();
    // Reset state.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 3, 1, 1);
    cycle(0, 0, 0, 0, 0, 0);
    // Errors: release while full, commit with nothing speculative; both stick.
    cycle(0, 0, 1, 5, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    // Drain: 23 allocs, the last one with the list empty.
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 23; i++) cycle(0, 1, 0, 0, 0, 0);
    // Commit everything, then release into the empty list.
    for (int i = 0; i < 22; i++) cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 1, 1, 3, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, tag_t'(20 + i), 0, 0);
    cycle(0, 1, 1, 9, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    // Flush: 5 allocs, 2 commits, flush.
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);
    // Same-cycle flush, commit and release after 3 allocs.
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 1, 7, 1, 1);
    cycle(0, 0, 0, 0, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 99) < 55),
            ($urandom_range(0, 99) < 40),
            tag_t'($urandom_range(0, 31)),
            ($urandom_range(0, 99) < 35),
            ($urandom_range(0, 99) < 4));
    end
    cycle(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
